charge_controller: RTL and testbench



---
 rtl/coin_charger_pkg.sv | 31 +++
 rtl/charge_controller_if.sv | 18 +
 rtl/key_event_decoder.sv | 38 +++
 rtl/charge_controller.sv | 161 ++++++++++++++++
 tb/tb_charge_controller.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/coin_charger_pkg.sv
// Shared types and constants for the coin charger: state codes, key classes
// and parameter defaults.
package coin_charger_pkg;

   localparam int unsigned MAX_AMOUNT_DEF    = 20;
   localparam int unsigned TIME_PER_COIN_DEF = 45;
   localparam int unsigned TIMEOUT_DEF       = 10;

   localparam logic [3:0] KEY_NO_DIGIT = 4'hF;

   localparam logic [3:0] ST_IDLE   = 4'b0001;
   localparam logic [3:0] ST_ENTRY  = 4'b0010;
   localparam logic [3:0] ST_CHARGE = 4'b0100;
   localparam logic [3:0] ST_FINISH = 4'b1000;

   typedef enum logic [3:0] {
      S_IDLE   = ST_IDLE,
      S_ENTRY  = ST_ENTRY,
      S_CHARGE = ST_CHARGE,
      S_FINISH = ST_FINISH
   } state_e;

   typedef enum logic [2:0] {
      KC_NONE,
      KC_DIGIT,
      KC_START,
      KC_RESET,
      KC_OK
   } key_class_e;

endpackage

// File: rtl/charge_controller_if.sv
// Keypad-scanner bundle consumed by the charge controller.
interface charge_controller_if;

   logic [3:0] key_data;
   logic       key_start;
   logic       key_reset;
   logic       key_ok;
   logic       key_idle;

   modport master (
      output key_data, key_start, key_reset, key_ok, key_idle
   );

   modport slave (
      input  key_data, key_start, key_reset, key_ok, key_idle
   );

endinterface

// File: rtl/key_event_decoder.sv
// Turns the scanner's idle flag into one event per keypress and classifies
// the key with priority reset > start > ok > digit.
module key_event_decoder
   import coin_charger_pkg::*;
(
   input  logic                CLK,
   input  logic                rst_n,
   charge_controller_if.slave  keys,
   output logic                key_ev_o,
   output key_class_e          key_class_o,
   output logic [3:0]          digit_o
);

   logic idle_q;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) idle_q <= 1'b1;
      else        idle_q <= keys.key_idle;
   end

   assign key_ev_o = idle_q & ~keys.key_idle;

   // Codes 10..14 with no control key fall through as KC_NONE.
   always_comb begin
      key_class_o = KC_NONE;
      digit_o     = KEY_NO_DIGIT;
      if (key_ev_o) begin
         if (keys.key_reset)             key_class_o = KC_RESET;
         else if (keys.key_start)        key_class_o = KC_START;
         else if (keys.key_ok)           key_class_o = KC_OK;
         else if (keys.key_data <= 4'd9) begin
            key_class_o = KC_DIGIT;
            digit_o     = keys.key_data;
         end
      end
   end

endmodule

// File: rtl/charge_controller.sv
// Coin charger sequencer: amount-entry dialogue, entry timeout and
// tick-driven countdown of the granted charge time.
module charge_controller
   import coin_charger_pkg::*;
#(
   parameter int unsigned MAX_AMOUNT    = MAX_AMOUNT_DEF,
   parameter int unsigned TIME_PER_COIN = TIME_PER_COIN_DEF,
   parameter int unsigned TIMEOUT       = TIMEOUT_DEF
) (
   input  logic                CLK,
   input  logic                rst_n,
   input  logic                tick,
   charge_controller_if.slave  keys,
   output logic [4:0]          amount,
   output logic [9:0]          remain,
   output logic                charging,
   output logic                entering,
   output logic                done,
   output logic                error,
   output logic [3:0]          state_view
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [8:0]    MAX_A9   = 9'(MAX_AMOUNT);
   localparam logic [9:0]    TPC10    = 10'(TIME_PER_COIN);

   if (MAX_AMOUNT * TIME_PER_COIN > 1023) begin : g_chk_remain_width
      $error("MAX_AMOUNT*TIME_PER_COIN exceeds the 10-bit remain counter");
   end
   if (MAX_AMOUNT > 31) begin : g_chk_amount_width
      $error("MAX_AMOUNT exceeds the 5-bit amount register");
   end
   if (TIMEOUT < 1) begin : g_chk_timeout
      $error("TIMEOUT must be at least 1");
   end

   logic       key_ev;
   key_class_e key_class;
   logic [3:0] digit;

   key_event_decoder u_dec (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .keys        (keys),
      .key_ev_o    (key_ev),
      .key_class_o (key_class),
      .digit_o     (digit)
   );

   state_e        state_q,  state_d;
   logic [4:0]    amount_q, amount_d;
   logic [9:0]    remain_q, remain_d;
   logic [TW-1:0] tmo_q,    tmo_d;
   logic          error_q,  error_d;

   logic [8:0] cand;
   logic [9:0] prod;

   assign cand = ({4'b0, amount_q} * 9'd10) + {5'b0, digit};
   assign prod = {5'b0, amount_q} * TPC10;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         amount_q <= '0;
         remain_q <= '0;
         tmo_q    <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         amount_q <= amount_d;
         remain_q <= remain_d;
         tmo_q    <= tmo_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      amount_d = amount_q;
      remain_d = remain_q;
      tmo_d    = tmo_q;
      error_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            amount_d = '0;
            remain_d = '0;
            if (key_class == KC_START) begin
               state_d = S_ENTRY;
               tmo_d   = '0;
            end
         end
         S_ENTRY: begin
            // Any key event, even an ignored one, restarts the timeout and
            // takes precedence over a coincident tick.
            if (key_ev) begin
               tmo_d = '0;
               case (key_class)
                  KC_DIGIT: begin
                     if (cand <= MAX_A9) amount_d = cand[4:0];
                     else                error_d  = 1'b1;
                  end
                  KC_RESET: amount_d = '0;
                  KC_OK: begin
                     if (amount_q == '0) begin
                        error_d = 1'b1;
                     end else begin
                        remain_d = prod;
                        state_d  = S_CHARGE;
                     end
                  end
                  default: ;
               endcase
            end else if (tick) begin
               if (tmo_q == TMO_LAST) begin
                  state_d  = S_IDLE;
                  amount_d = '0;
                  tmo_d    = '0;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
         end
         S_CHARGE: begin
            if (key_class == KC_RESET) begin
               state_d  = S_IDLE;
               amount_d = '0;
               remain_d = '0;
            end else if (tick) begin
               if (remain_q == 10'd1) begin
                  remain_d = '0;
                  state_d  = S_FINISH;
               end else begin
                  remain_d = remain_q - 10'd1;
               end
            end
         end
         S_FINISH: begin
            state_d  = S_IDLE;
            amount_d = '0;
            remain_d = '0;
         end
         default: begin
            state_d  = S_IDLE;
            amount_d = '0;
            remain_d = '0;
            tmo_d    = '0;
         end
      endcase
   end

   assign amount     = amount_q;
   assign remain     = remain_q;
   assign charging   = (state_q == S_CHARGE);
   assign entering   = (state_q == S_ENTRY);
   assign done       = (state_q == S_FINISH);
   assign error      = error_q;
   assign state_view = state_q;

endmodule

// File: tb/tb_charge_controller.sv
// Directed self-checking bench for charge_controller with hand-computed
// expectations (TIME_PER_COIN=45, MAX_AMOUNT=20, TIMEOUT=10).
module tb_charge_controller;
   import coin_charger_pkg::*;

   logic       CLK = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic [4:0] amount;
   logic [9:0] remain;
   logic       charging, entering, done, error;
   logic [3:0] state_view;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int err_base;

   logic [4:0] s_amt;
   logic [9:0] s_rem;
   logic       s_err, s_chg;
   logic [3:0] s_st;

   charge_controller_if kif ();

   charge_controller #(
      .MAX_AMOUNT    (20),
      .TIME_PER_COIN (45),
      .TIMEOUT       (10)
   ) dut (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .tick       (tick),
      .keys       (kif),
      .amount     (amount),
      .remain     (remain),
      .charging   (charging),
      .entering   (entering),
      .done       (done),
      .error      (error),
      .state_view (state_view)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (done)  done_cnt++;
      if (error) err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_keys();
      kif.key_data  = KEY_NO_DIGIT;
      kif.key_start = 1'b0;
      kif.key_reset = 1'b0;
      kif.key_ok    = 1'b0;
      kif.key_idle  = 1'b1;
   endtask

   // One keypress: event cycle (optionally with a tick), snapshot, release cycle.
   task automatic key(input logic [3:0] d, input logic s, input logic r,
                      input logic o, input logic with_tick);
      kif.key_data  = d;
      kif.key_start = s;
      kif.key_reset = r;
      kif.key_ok    = o;
      kif.key_idle  = 1'b0;
      tick          = with_tick;
      @(negedge CLK);
      s_amt = amount; s_rem = remain; s_err = error; s_chg = charging; s_st = state_view;
      tick = 1'b0;
      idle_keys();
      @(negedge CLK);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         @(negedge CLK);
      end
      tick = 1'b0;
   endtask

   initial begin
      idle_keys();
      @(negedge CLK);
      chk("rst_amount",   32'(amount), 0);
      chk("rst_remain",   32'(remain), 0);
      chk("rst_charging", 32'(charging), 0);
      chk("rst_entering", 32'(entering), 0);
      chk("rst_done",     32'(done), 0);
      chk("rst_error",    32'(error), 0);
      chk("rst_state",    32'(state_view), 32'b0001);
      rst_n = 1'b1;
      @(negedge CLK);

      // Full charge: start, 1, 5, ok -> 15 coins, 675 units
      key(4'hF, 1, 0, 0, 0);
      chk("start_state", 32'(s_st), 32'b0010);
      chk("start_entering", 32'(entering), 1);
      key(4'd1, 0, 0, 0, 0);
      chk("digit1_amount", 32'(amount), 1);
      key(4'd5, 0, 0, 0, 0);
      chk("digit5_amount", 32'(amount), 15);
      key(4'hF, 0, 0, 1, 0);
      chk("ok_charging", 32'(s_chg), 1);
      chk("ok_remain", 32'(s_rem), 675);
      chk("ok_state", 32'(s_st), 32'b0100);
      ticks(674);
      chk("remain_last", 32'(remain), 1);
      chk("charging_last", 32'(charging), 1);
      chk("no_early_done", 32'(done_cnt), 0);
      ticks(1);
      chk("done_pulse", 32'(done), 1);
      chk("finish_state", 32'(state_view), 32'b1000);
      chk("finish_remain", 32'(remain), 0);
      @(negedge CLK);
      chk("done_low", 32'(done), 0);
      chk("back_idle", 32'(state_view), 32'b0001);
      chk("idle_amount", 32'(amount), 0);
      chk("done_once", 32'(done_cnt), 1);

      // Over-limit digit, reset key, ok with zero amount
      key(4'hF, 1, 0, 0, 0);
      key(4'd2, 0, 0, 0, 0);
      chk("digit2_amount", 32'(amount), 2);
      key(4'd5, 0, 0, 0, 0);
      chk("over_error", 32'(s_err), 1);
      chk("over_amount", 32'(s_amt), 2);
      chk("over_error_pulse", 32'(error), 0);
      key(4'hF, 0, 1, 0, 0);
      chk("rstkey_amount", 32'(amount), 0);
      chk("rstkey_state", 32'(state_view), 32'b0010);
      key(4'hF, 0, 0, 1, 0);
      chk("ok0_error", 32'(s_err), 1);
      chk("ok0_state", 32'(s_st), 32'b0010);

      // Timeout after 10 ticks without a key
      key(4'd3, 0, 0, 0, 0);
      chk("digit3_amount", 32'(amount), 3);
      ticks(9);
      chk("tmo9_state", 32'(state_view), 32'b0010);
      ticks(1);
      chk("tmo10_state", 32'(state_view), 32'b0001);
      chk("tmo10_amount", 32'(amount), 0);
      chk("tmo10_entering", 32'(entering), 0);

      // Key coinciding with the 10th tick clears the counter instead
      key(4'hF, 1, 0, 0, 0);
      ticks(9);
      key(4'd7, 0, 0, 0, 1);
      chk("coinc_state", 32'(s_st), 32'b0010);
      chk("coinc_amount", 32'(s_amt), 7);
      ticks(9);
      chk("coinc_tmo9_state", 32'(state_view), 32'b0010);
      ticks(1);
      chk("coinc_tmo10_state", 32'(state_view), 32'b0001);

      // Abort in CHARGE with remain=3, reset key coinciding with a tick
      key(4'hF, 1, 0, 0, 0);
      key(4'd1, 0, 0, 0, 0);
      key(4'hF, 0, 0, 1, 0);
      chk("one_coin_remain", 32'(remain), 45);
      ticks(42);
      chk("remain3", 32'(remain), 3);
      key(4'hF, 0, 1, 0, 1);
      chk("abort_state", 32'(s_st), 32'b0001);
      chk("abort_remain", 32'(s_rem), 0);
      chk("abort_charging", 32'(s_chg), 0);
      ticks(3);
      chk("abort_no_done", 32'(done_cnt), 1);

      // Held key: exactly one digit event
      key(4'hF, 1, 0, 0, 0);
      err_base = err_cnt;
      kif.key_data = 4'd7;
      kif.key_idle = 1'b0;
      repeat (100) @(negedge CLK);
      idle_keys();
      @(negedge CLK);
      chk("held_amount", 32'(amount), 7);
      chk("held_no_error", 32'(err_cnt - err_base), 0);
      chk("held_state", 32'(state_view), 32'b0010);

      // Asynchronous reset mid-charge
      key(4'hF, 0, 0, 1, 0);
      chk("seven_remain", 32'(remain), 315);
      ticks(5);
      chk("remain310", 32'(remain), 310);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_amount",   32'(amount), 0);
      chk("arst_remain",   32'(remain), 0);
      chk("arst_charging", 32'(charging), 0);
      chk("arst_done",     32'(done), 0);
      chk("arst_state",    32'(state_view), 32'b0001);
      @(negedge CLK);
      rst_n = 1'b1;
      repeat (3) @(negedge CLK);
      chk("arst_no_done", 32'(done_cnt), 1);
      chk("arst_idle", 32'(state_view), 32'b0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
